// File: rtl/evt_scheduler_pkg.sv
// rtl/evt_scheduler_pkg.sv - shared constants and types for the event scheduler
package evt_scheduler_pkg;

   typedef enum logic {
      LOAD_IMM = 1'b0,
      LOAD_DEF = 1'b1
   } load_mode_e;

   // All-ones compare value marks a channel as disarmed; supports widths up to 64.
   function automatic logic [63:0] disarmed(input int tw);
      return (tw >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << tw) - 64'd1);
   endfunction

endpackage

// File: rtl/evt_channel.sv
// rtl/evt_channel.sv - one compare channel: active/shadow registers, pulse timer, sticky flag
module evt_channel
   import evt_scheduler_pkg::*;
#(
   parameter int TW      = 32,
   parameter int PULSE_W = 14
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [TW-1:0] time_now_i,
   input  logic          ld_act_i,
   input  logic          ld_shd_i,
   input  logic [TW-1:0] ld_val_i,
   input  logic          commit_i,
   input  logic          flag_clr_i,
   output logic          pulse_o,
   output logic          start_o,
   output logic          flag_o
);
   localparam int CW = $clog2(PULSE_W + 1);
   localparam logic [TW-1:0] DISARMED = TW'(disarmed(TW));

   logic [TW-1:0] active_q, active_d, shadow_q, shadow_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          start_q, flag_q, flag_d;
   logic          match, fire;

   assign match = (active_q == time_now_i) && (active_q != '0) &&
                  (active_q != DISARMED) && (cnt_q == '0);
   // An immediate load landing on a matching cycle replaces the compare value instead of firing.
   assign fire  = match && !ld_act_i;

   always_comb begin
      active_d = active_q;
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      flag_d   = flag_q;
      if (fire)     active_d = DISARMED;
      if (commit_i) begin
         active_d = shadow_q;
         shadow_d = DISARMED;
      end
      if (ld_act_i) active_d = ld_val_i;
      if (ld_shd_i) shadow_d = ld_val_i;
      if (fire)               cnt_d = CW'(PULSE_W);
      else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
      if (start_q)            flag_d = 1'b1;
      else if (flag_clr_i)    flag_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= DISARMED;
         shadow_q <= DISARMED;
         cnt_q    <= '0;
         start_q  <= 1'b0;
         flag_q   <= 1'b0;
      end else begin
         active_q <= active_d;
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
         start_q  <= fire;
         flag_q   <= flag_d;
      end
   end

   assign pulse_o = (cnt_q != '0);
   assign start_o = start_q;
   assign flag_o  = flag_q;

endmodule

// File: rtl/evt_scheduler.sv
// rtl/evt_scheduler.sv - microsecond time base with one-shot compare channels and interval tracking
module evt_scheduler
   import evt_scheduler_pkg::*;
#(
   parameter int N_CH      = 8,
   parameter int TW        = 32,
   parameter int PULSE_W   = 14,
   parameter int RST_HOLD  = 20,
   parameter int COMMIT_CH = 0
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick_1us,
   input  logic               sync_in,
   input  logic               load_stb,
   input  logic               load_mode,
   input  logic [N_CH-1:0]    load_en,
   input  logic [N_CH*TW-1:0] load_time,
   input  logic [N_CH-1:0]    flag_clr,
   input  logic               err_clr,
   output logic [TW-1:0]      time_now,
   output logic               time_rst,
   output logic [N_CH-1:0]    ev_pulse,
   output logic [N_CH-1:0]    ev_flag,
   output logic               flag_parity,
   output logic [N_CH/2-1:0]  interval,
   output logic               overlap_err
);
   localparam int HW = $clog2(RST_HOLD + 1);
   localparam int NP = N_CH / 2;

   logic [1:0]    tick_sync_q, sync_sync_q;
   logic          tick_dly_q, sync_dly_q, tick_edge, sync_edge;
   logic [TW-1:0] time_q, time_d;
   logic          trst_q, trst_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [N_CH-1:0] ch_start;
   logic [NP-1:0] interval_q, interval_d;
   logic          err_q, err_d, err_set, parity_q;
   logic          load_imm, load_def;

   assign tick_edge = tick_sync_q[1] & ~tick_dly_q;
   assign sync_edge = sync_sync_q[1] & ~sync_dly_q;

   always_comb begin
      time_d = time_q;
      trst_d = trst_q;
      hold_d = hold_q;
      if (sync_edge) begin
         time_d = '0;
         trst_d = 1'b1;
         hold_d = '0;
      end else if (tick_edge) begin
         time_d = time_q + 1'b1;
         if (trst_q) begin
            hold_d = hold_q + 1'b1;
            if (hold_q == HW'(RST_HOLD - 1)) trst_d = 1'b0;
         end
      end
   end

   assign load_imm = load_stb && (load_mode_e'(load_mode) == LOAD_IMM);
   assign load_def = load_stb && (load_mode_e'(load_mode) == LOAD_DEF);

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      evt_channel #(.TW(TW), .PULSE_W(PULSE_W)) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .time_now_i (time_q),
         .ld_act_i   (load_imm && load_en[k]),
         .ld_shd_i   (load_def && load_en[k]),
         .ld_val_i   (load_time[k*TW +: TW]),
         .commit_i   (ch_start[COMMIT_CH]),
         .flag_clr_i (flag_clr[k]),
         .pulse_o    (ev_pulse[k]),
         .start_o    (ch_start[k]),
         .flag_o     (ev_flag[k])
      );
   end

   // Even channel opens its pair's interval, odd channel closes it; close wins.
   always_comb begin
      interval_d = interval_q;
      err_set    = 1'b0;
      for (int p = 0; p < NP; p++) begin
         if (ch_start[2*p+1])    interval_d[p] = 1'b0;
         else if (ch_start[2*p]) interval_d[p] = 1'b1;
         for (int q = 0; q < NP; q++) begin
            if (ch_start[2*p] && (q != p) && interval_q[q]) err_set = 1'b1;
         end
      end
      err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_sync_q <= '0;
         sync_sync_q <= '0;
         tick_dly_q  <= 1'b0;
         sync_dly_q  <= 1'b0;
         time_q      <= '0;
         trst_q      <= 1'b0;
         hold_q      <= '0;
         interval_q  <= '0;
         err_q       <= 1'b0;
         parity_q    <= 1'b0;
      end else begin
         tick_sync_q <= {tick_sync_q[0], tick_1us};
         sync_sync_q <= {sync_sync_q[0], sync_in};
         tick_dly_q  <= tick_sync_q[1];
         sync_dly_q  <= sync_sync_q[1];
         time_q      <= time_d;
         trst_q      <= trst_d;
         hold_q      <= hold_d;
         interval_q  <= interval_d;
         err_q       <= err_d;
         parity_q    <= ^ev_flag;
      end
   end

   assign time_now    = time_q;
   assign time_rst    = trst_q;
   assign interval    = interval_q;
   assign overlap_err = err_q;
   assign flag_parity = parity_q;

endmodule

// File: tb/tb_evt_scheduler.sv
// tb/tb_evt_scheduler.sv - directed self-checking bench for evt_scheduler
module tb_evt_scheduler;
   localparam int N  = 8;
   localparam int TW = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            tick_1us = 1'b0;
   logic            sync_in = 1'b0;
   logic            load_stb = 1'b0;
   logic            load_mode = 1'b0;
   logic [N-1:0]    load_en = '0;
   logic [N*TW-1:0] load_time = '0;
   logic [N-1:0]    flag_clr = '0;
   logic            err_clr = 1'b0;
   logic [TW-1:0]   time_now;
   logic            time_rst;
   logic [N-1:0]    ev_pulse;
   logic [N-1:0]    ev_flag;
   logic            flag_parity;
   logic [N/2-1:0]  interval;
   logic            overlap_err;
   logic            tick_en = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   evt_scheduler #(.N_CH(N), .TW(TW), .PULSE_W(14), .RST_HOLD(20), .COMMIT_CH(0)) dut (
      .clk(clk), .rst_n(rst_n), .tick_1us(tick_1us), .sync_in(sync_in),
      .load_stb(load_stb), .load_mode(load_mode), .load_en(load_en), .load_time(load_time),
      .flag_clr(flag_clr), .err_clr(err_clr), .time_now(time_now), .time_rst(time_rst),
      .ev_pulse(ev_pulse), .ev_flag(ev_flag), .flag_parity(flag_parity),
      .interval(interval), .overlap_err(overlap_err)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         repeat (4) @(negedge clk);
         tick_1us = tick_en;
         repeat (2) @(negedge clk);
         tick_1us = 1'b0;
      end
   end

   task automatic wait_time(input logic [TW-1:0] t);
      int n = 0;
      while (time_now !== t && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (time_now !== t) begin
         n_cmp++; n_err++;
         $display("FAIL wait_time: time_now=%0d never reached %0d", time_now, t);
      end
   endtask

   task automatic do_sync();
      @(negedge clk);
      sync_in = 1'b1;
      repeat (3) @(negedge clk);
      sync_in = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_load(input logic mode, input int ch, input logic [TW-1:0] v);
      load_mode = mode;
      load_en   = N'(1 << ch);
      load_time = '0;
      load_time[ch*TW +: TW] = v;
      load_stb  = 1'b1;
      @(negedge clk);
      load_stb  = 1'b0;
      load_en   = '0;
   endtask

   task automatic clear_flags();
      flag_clr = '1;
      @(negedge clk);
      flag_clr = '0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++; if (time_now !== 8'd0) begin n_err++; $display("FAIL rst_time_now got %0d want 0", time_now); end
      n_cmp++; if (time_rst !== 1'b0) begin n_err++; $display("FAIL rst_time_rst got %b want 0", time_rst); end
      n_cmp++; if (ev_pulse !== 8'h00) begin n_err++; $display("FAIL rst_ev_pulse got %h want 00", ev_pulse); end
      n_cmp++; if (ev_flag !== 8'h00) begin n_err++; $display("FAIL rst_ev_flag got %h want 00", ev_flag); end
      n_cmp++; if ({flag_parity, overlap_err, interval} !== 6'd0) begin n_err++; $display("FAIL rst_misc got %b want 000000", {flag_parity, overlap_err, interval}); end
      rst_n = 1'b1;
      tick_en = 1'b1;
      repeat (20) @(negedge clk);
      n_cmp++; if (time_rst !== 1'b0) begin n_err++; $display("FAIL idle_time_rst got %b want 0", time_rst); end
   endtask

   task automatic test_sync_hold();
      int n = 0;
      sync_in = 1'b1;
      while (time_rst !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      n_cmp++; if (time_rst !== 1'b1 || time_now !== 8'd0) begin n_err++; $display("FAIL sync_edge got rst=%b time=%0d want 1/0", time_rst, time_now); end
      repeat (3) @(negedge clk);
      sync_in = 1'b0;
      wait_time(8'd19);
      n_cmp++; if (time_rst !== 1'b1) begin n_err++; $display("FAIL hold_19 got %b want 1", time_rst); end
      wait_time(8'd20);
      n_cmp++; if (time_rst !== 1'b0) begin n_err++; $display("FAIL hold_20 got %b want 0", time_rst); end
   endtask

   task automatic test_immediate();
      int w = 0;
      do_sync();
      clear_flags();
      do_load(1'b0, 2, 8'd5);
      wait_time(8'd5);
      n_cmp++; if (ev_pulse[2] !== 1'b0) begin n_err++; $display("FAIL imm_match_cycle got %b want 0", ev_pulse[2]); end
      @(negedge clk);
      while (ev_pulse[2] === 1'b1 && w < 40) begin w++; @(negedge clk); end
      n_cmp++; if (w != 14) begin n_err++; $display("FAIL imm_width got %0d want 14", w); end
      n_cmp++; if (ev_flag !== 8'h04) begin n_err++; $display("FAIL imm_flag got %h want 04", ev_flag); end
      n_cmp++; if (flag_parity !== 1'b1) begin n_err++; $display("FAIL imm_parity got %b want 1", flag_parity); end
      flag_clr = 8'h04;
      @(negedge clk);
      flag_clr = '0;
      wait_time(8'd255);
      wait_time(8'd8);
      n_cmp++; if (ev_flag[2] !== 1'b0 || ev_pulse[2] !== 1'b0) begin n_err++; $display("FAIL imm_wrap got flag=%b pulse=%b want 0/0", ev_flag[2], ev_pulse[2]); end
   endtask

   task automatic test_deferred();
      do_sync();
      clear_flags();
      do_load(1'b1, 3, 8'd40);
      do_load(1'b0, 0, 8'd10);
      wait_time(8'd10);
      @(negedge clk);
      n_cmp++; if (ev_pulse[0] !== 1'b1) begin n_err++; $display("FAIL def_commit_pulse got %b want 1", ev_pulse[0]); end
      wait_time(8'd39);
      n_cmp++; if (ev_pulse[3] !== 1'b0 || ev_flag[3] !== 1'b0) begin n_err++; $display("FAIL def_early got pulse=%b flag=%b want 0/0", ev_pulse[3], ev_flag[3]); end
      wait_time(8'd41);
      n_cmp++; if (ev_pulse[3] !== 1'b1 || ev_flag[3] !== 1'b1) begin n_err++; $display("FAIL def_fire got pulse=%b flag=%b want 1/1", ev_pulse[3], ev_flag[3]); end
      clear_flags();
      do_load(1'b1, 3, 8'd60);
      wait_time(8'd62);
      n_cmp++; if (ev_flag[3] !== 1'b0 || ev_pulse[3] !== 1'b0) begin n_err++; $display("FAIL def_nocommit got flag=%b pulse=%b want 0/0", ev_flag[3], ev_pulse[3]); end
   endtask

   task automatic test_never_fire();
      do_sync();
      clear_flags();
      do_load(1'b0, 1, 8'd0);
      wait_time(8'd4);
      n_cmp++; if (ev_flag[1] !== 1'b0) begin n_err++; $display("FAIL zero_armed got %b want 0", ev_flag[1]); end
      do_load(1'b0, 1, 8'hFF);
      wait_time(8'd254);
      wait_time(8'd2);
      n_cmp++; if (ev_flag[1] !== 1'b0 || ev_pulse[1] !== 1'b0) begin n_err++; $display("FAIL ones_armed got flag=%b pulse=%b want 0/0", ev_flag[1], ev_pulse[1]); end
   endtask

   task automatic test_flag_clr();
      int n = 0;
      do_sync();
      clear_flags();
      @(negedge clk);
      n_cmp++; if (flag_parity !== 1'b0) begin n_err++; $display("FAIL fc_parity0 got %b want 0", flag_parity); end
      do_load(1'b0, 4, 8'd6);
      while (ev_pulse[4] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      flag_clr = 8'h10;
      @(negedge clk);
      flag_clr = '0;
      n_cmp++; if (ev_flag[4] !== 1'b1) begin n_err++; $display("FAIL fc_set_wins got %b want 1", ev_flag[4]); end
      n_cmp++; if (flag_parity !== 1'b0) begin n_err++; $display("FAIL fc_parity_lag got %b want 0", flag_parity); end
      @(negedge clk);
      n_cmp++; if (flag_parity !== 1'b1) begin n_err++; $display("FAIL fc_parity_set got %b want 1", flag_parity); end
      flag_clr = 8'h10;
      @(negedge clk);
      flag_clr = '0;
      n_cmp++; if (ev_flag[4] !== 1'b0 || flag_parity !== 1'b1) begin n_err++; $display("FAIL fc_clear got flag=%b par=%b want 0/1", ev_flag[4], flag_parity); end
      @(negedge clk);
      n_cmp++; if (flag_parity !== 1'b0) begin n_err++; $display("FAIL fc_parity_clr got %b want 0", flag_parity); end
   endtask

   task automatic test_reset_mid();
      do_sync();
      clear_flags();
      do_load(1'b0, 5, 8'd4);
      wait_time(8'd4);
      repeat (2) @(negedge clk);
      n_cmp++; if (ev_pulse[5] !== 1'b1 || time_rst !== 1'b1) begin n_err++; $display("FAIL rm_pre got pulse=%b rst=%b want 1/1", ev_pulse[5], time_rst); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (ev_pulse !== 8'h00 || time_rst !== 1'b0 || time_now !== 8'd0) begin n_err++; $display("FAIL rm_async got pulse=%h rst=%b time=%0d want 00/0/0", ev_pulse, time_rst, time_now); end
      n_cmp++; if (ev_flag !== 8'h00 || {flag_parity, overlap_err, interval} !== 6'd0) begin n_err++; $display("FAIL rm_async_misc got flag=%h misc=%b want 00/000000", ev_flag, {flag_parity, overlap_err, interval}); end
      tick_en = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      n_cmp++; if (time_now !== 8'd0 || time_rst !== 1'b0) begin n_err++; $display("FAIL rm_no_edge got time=%0d rst=%b want 0/0", time_now, time_rst); end
      tick_en = 1'b1;
      do_sync();
      n_cmp++; if (time_rst !== 1'b1) begin n_err++; $display("FAIL rm_resync got %b want 1", time_rst); end
   endtask

   task automatic test_overlap();
      clear_flags();
      do_load(1'b1, 2, 8'd12);
      do_load(1'b1, 1, 8'd20);
      do_load(1'b0, 0, 8'd10);
      wait_time(8'd11);
      n_cmp++; if (interval !== 4'b0001 || overlap_err !== 1'b0) begin n_err++; $display("FAIL ov_open got int=%b err=%b want 0001/0", interval, overlap_err); end
      wait_time(8'd13);
      n_cmp++; if (interval !== 4'b0011 || overlap_err !== 1'b1) begin n_err++; $display("FAIL ov_err got int=%b err=%b want 0011/1", interval, overlap_err); end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      n_cmp++; if (overlap_err !== 1'b0) begin n_err++; $display("FAIL ov_clr got %b want 0", overlap_err); end
      wait_time(8'd21);
      n_cmp++; if (interval !== 4'b0010) begin n_err++; $display("FAIL ov_close got %b want 0010", interval); end
   endtask

   initial begin
      test_reset();
      test_sync_hold();
      test_immediate();
      test_deferred();
      test_never_fire();
      test_flag_clr();
      test_reset_mid();
      test_overlap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
